// File: rtl/lfsr_msg_encoder_if.sv
// ----------------------------------------------------------------------------
// lfsr_msg_encoder_if
//
// Memory bus between the LFSR message encoder and the lab data memory.
// There is one combinational read port and one posedge-sampled write port.
//
//   raddr     read address            (master -> memory)
//   rdata     read data, combinational (memory -> master)
//   write_en  write strobe            (master -> memory)
//   waddr     write address           (master -> memory)
//   wdata     write data              (master -> memory)
//
// Modports:
//   master  the encoder; it drives the addresses and the write strobe
//   slave   the data memory; it returns read data
// ----------------------------------------------------------------------------
interface lfsr_msg_encoder_if;
    logic [7:0] raddr;
    logic [7:0] rdata;
    logic       write_en;
    logic [7:0] waddr;
    logic [7:0] wdata;

    modport master (
        output raddr,
        output write_en,
        output waddr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  raddr,
        input  write_en,
        input  waddr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/lfsr_msg_encoder.sv
// ----------------------------------------------------------------------------
// lfsr_msg_encoder
//
// This is the upstream encryption stage of the lab 5 datapath.
//
// It first reads three configuration bytes from data memory:
//   - the preamble length,
//   - the tap select,
//   - the LFSR seed.
// It then writes a FRAME_LEN-character encrypted frame starting at OUT_BASE.
//
// Frame contents:
//   - The frame is a preamble of PAD_CHAR followed by the plaintext message.
//   - Each character has its low 6 bits XORed with a 6-bit LFSR.
//   - The LFSR advances once per character.
//
// Ports:
//   clk    rising-edge clock
//   init   synchronous active-high reset; the block runs once after release
//   bus    memory bus (master side), see lfsr_msg_encoder_if
//   taps   tap pattern in use; valid from RD_SEED through DONE
//   busy   high while reading the configuration or encoding
//   done   high once the frame is written; held until init
// ----------------------------------------------------------------------------
module lfsr_msg_encoder #(
    parameter int unsigned MSG_BASE  = 0,
    parameter int unsigned OUT_BASE  = 64,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned PREL_ADDR = 61,
    parameter int unsigned TAP_ADDR  = 62,
    parameter int unsigned SEED_ADDR = 63,
    parameter logic [7:0]  PAD_CHAR  = 8'h5F
) (
    input  logic                clk,
    input  logic                init,
    lfsr_msg_encoder_if.master  bus,
    output logic [5:0]          taps,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_PREL,
        RD_TAP,
        RD_SEED,
        ENC,
        DONE
    } state_t;

    localparam logic [7:0] MSG_BASE_B  = 8'(MSG_BASE);
    localparam logic [7:0] OUT_BASE_B  = 8'(OUT_BASE);
    localparam logic [7:0] PREL_ADDR_B = 8'(PREL_ADDR);
    localparam logic [7:0] TAP_ADDR_B  = 8'(TAP_ADDR);
    localparam logic [7:0] SEED_ADDR_B = 8'(SEED_ADDR);
    localparam logic [6:0] LAST_J      = 7'(FRAME_LEN - 1);

    // The decoder needs at least 7 pad characters to lock on.
    // The frame layout caps the preamble at 12 characters.
    localparam logic [3:0] PREL_MIN = 4'd7;
    localparam logic [3:0] PREL_MAX = 4'd12;

    state_t     state, state_nxt;
    logic [6:0] j, j_nxt;
    logic [5:0] lfsr, lfsr_nxt;
    logic [3:0] prel, prel_nxt;
    logic [5:0] taps_nxt;
    logic [7:0] plain;
    logic       feedback;

    // Clamp the raw preamble-length byte into PREL_MIN..PREL_MAX.
    function automatic logic [3:0] clamp_prel(input logic [7:0] raw);
        if (raw < 8'(PREL_MIN))
            return PREL_MIN;
        else if (raw > 8'(PREL_MAX))
            return PREL_MAX;
        else
            return raw[3:0];
    endfunction

    // Map the tap select to one of the six maximal-length tap patterns.
    // Out-of-range selects (6, 7) fall back to pattern 0.
    function automatic logic [5:0] tap_lookup(input logic [2:0] sel);
        case (sel)
            3'd1:    return 6'h2D;
            3'd2:    return 6'h30;
            3'd3:    return 6'h33;
            3'd4:    return 6'h36;
            3'd5:    return 6'h39;
            default: return 6'h21;
        endcase
    endfunction

    // Feedback bit: the parity of the tapped LFSR bits.
    assign feedback = ^(lfsr & taps);

    // NOTE: state is updated with non-blocking assignments only.
    // Reset is synchronous: init is sampled on the clock edge like any other input.
    always_ff @(posedge clk) begin
        if (init) begin
            state <= IDLE;
            j     <= '0;
            lfsr  <= '0;
            prel  <= '0;
            taps  <= '0;
        end else begin
            state <= state_nxt;
            j     <= j_nxt;
            lfsr  <= lfsr_nxt;
            prel  <= prel_nxt;
            taps  <= taps_nxt;
        end
    end

    // NOTE: every signal written here gets a default first.
    // The defaults make every path through the case assign a value, so no latches are inferred.
    always_comb begin
        state_nxt    = state;
        j_nxt        = j;
        lfsr_nxt     = lfsr;
        prel_nxt     = prel;
        taps_nxt     = taps;
        plain        = PAD_CHAR;
        bus.raddr    = '0;
        bus.write_en = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = RD_PREL;
            end

            RD_PREL: begin
                busy      = 1'b1;
                bus.raddr = PREL_ADDR_B;
                prel_nxt  = clamp_prel(bus.rdata);
                state_nxt = RD_TAP;
            end

            RD_TAP: begin
                busy      = 1'b1;
                bus.raddr = TAP_ADDR_B;
                taps_nxt  = tap_lookup(bus.rdata[2:0]);
                state_nxt = RD_SEED;
            end

            RD_SEED: begin
                busy      = 1'b1;
                bus.raddr = SEED_ADDR_B;
                // An all-zero LFSR never leaves zero, so replace a zero seed with 1.
                lfsr_nxt  = (bus.rdata[5:0] == 6'd0) ? 6'h01 : bus.rdata[5:0];
                j_nxt     = '0;
                state_nxt = ENC;
            end

            ENC: begin
                busy = 1'b1;
                // While in the preamble, park the read address on the message base.
                // The read data is unused until the message starts.
                if (j < {3'b000, prel}) begin
                    bus.raddr = MSG_BASE_B;
                    plain     = PAD_CHAR;
                end else begin
                    bus.raddr = MSG_BASE_B + {1'b0, j} - {4'b0000, prel};
                    plain     = bus.rdata;
                end
                bus.write_en = 1'b1;
                bus.waddr    = OUT_BASE_B + {1'b0, j};
                bus.wdata    = plain ^ {2'b00, lfsr};
                lfsr_nxt     = {lfsr[4:0], 1'b0} + {5'b00000, feedback};
                j_nxt        = j + 7'd1;
                if (j == LAST_J)
                    state_nxt = DONE;
            end

            DONE: begin
                done = 1'b1;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A reset landing mid-frame must not commit the character in flight.
        // The memory samples write_en on the same edge that reset takes effect.
        if (init)
            bus.write_en = 1'b0;
    end

endmodule

// File: tb/tb_lfsr_msg_encoder.sv
// ----------------------------------------------------------------------------
// tb_lfsr_msg_encoder
//
// Bench for lfsr_msg_encoder, built around a scoreboard.
//
// Data memory model:
//   - The message and configuration bytes live in in_mem (addresses 0..63).
//   - The encoder's writes land in out_mem (addresses 64..127).
//
// Checking:
//   - For each run, the stimulus computes the expected frame from the
//     encryption rules and queues one {addr, data} entry per write.
//   - A negedge monitor pops one entry for every write the DUT presents and
//     compares it.
// ----------------------------------------------------------------------------
module tb_lfsr_msg_encoder;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       init;
    logic [5:0] taps;
    logic       busy;
    logic       done;
    logic       clr_out;

    logic [7:0] in_mem  [0:63];
    logic [7:0] out_mem [0:63];
    wr_t        exp_q [$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    lfsr_msg_encoder_if bus ();

    lfsr_msg_encoder dut (
        .clk  (clk),
        .init (init),
        .bus  (bus),
        .taps (taps),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read and posedge write.
    assign bus.rdata = (bus.raddr < 8'd64) ? in_mem[bus.raddr[5:0]] : out_mem[bus.raddr[5:0]];

    always @(posedge clk) begin
        if (clr_out) begin
            for (int i = 0; i < 64; i++)
                out_mem[i] <= 8'hA5;
        end else if (bus.write_en === 1'b1 && bus.waddr >= 8'd64 && bus.waddr < 8'd128) begin
            out_mem[bus.waddr[5:0]] <= bus.wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (bus.write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_write: addr %0h data %0h with nothing expected", bus.waddr, bus.wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {24'd0, bus.waddr}, {24'd0, e.addr});
                check("write_data", {24'd0, bus.wdata}, {24'd0, e.data});
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model, computed from the encryption rules.
    // ------------------------------------------------------------------
    function automatic logic [5:0] model_taps(input logic [7:0] tap_b);
        logic [5:0] table_v [0:5];
        int sel;
        table_v = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
        sel = int'(tap_b[2:0]);
        if (sel > 5)
            sel = 0;
        return table_v[sel];
    endfunction

    task automatic build_expect(input logic [7:0] prel_b, input logic [7:0] tap_b,
                                input logic [7:0] seed_b, input int n_writes);
        int p, l, t, plain;
        wr_t e;
        p = int'(prel_b);
        if (p < 7)  p = 7;
        if (p > 12) p = 12;
        t = int'(model_taps(tap_b));
        l = int'(seed_b) % 64;
        if (l == 0) l = 1;
        exp_q.delete();
        for (int j = 0; j < n_writes; j++) begin
            plain  = (j < p) ? 'h5F : int'(in_mem[j - p]);
            e.addr = 8'(64 + j);
            e.data = 8'(plain ^ l);
            exp_q.push_back(e);
            l = ((l * 2) + ($countones(l & t) % 2)) % 64;
        end
    endtask

    task automatic fill_msg();
        for (int i = 0; i < 61; i++)
            in_mem[i] = 8'($urandom_range(32, 126));
    endtask

    // ------------------------------------------------------------------
    // One encoder run.
    //   stop_j < 64  : assert init during ENC cycle j = stop_j
    //   hold_chk     : after done, watch 100 idle cycles
    // ------------------------------------------------------------------
    task automatic run_enc(input logic [7:0] prel_b, input logic [7:0] tap_b,
                           input logic [7:0] seed_b, input int stop_j, input bit hold_chk);
        int done_edge;
        int bad;
        init        = 1'b1;
        clr_out     = 1'b1;
        in_mem[61]  = prel_b;
        in_mem[62]  = tap_b;
        in_mem[63]  = seed_b;
        build_expect(prel_b, tap_b, seed_b, (stop_j < 64) ? stop_j : 64);
        @(posedge clk); #1;
        clr_out = 1'b0;
        @(posedge clk); #1;
        check("rst_done",     {31'd0, done}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_write_en", {31'd0, bus.write_en}, 32'd0);
        check("rst_raddr",    {24'd0, bus.raddr}, 32'd0);
        check("rst_waddr",    {24'd0, bus.waddr}, 32'd0);
        check("rst_wdata",    {24'd0, bus.wdata}, 32'd0);
        check("rst_taps",     {26'd0, taps}, 32'd0);

        init      = 1'b0;
        done_edge = -1;
        // k counts posedges after the release: k = 0 is E0.
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (k == 2)
                check("taps_port", {26'd0, taps}, {26'd0, model_taps(tap_b)});
            if (k == 20) begin
                check("enc_busy", {31'd0, busy}, 32'd1);
                check("enc_done", {31'd0, done}, 32'd0);
            end
            if (stop_j < 64 && k == stop_j + 3) begin
                init = 1'b1;
                #1;
                check("abort_write_en", {31'd0, bus.write_en}, 32'd0);
                break;
            end
            if (done === 1'b1) begin
                done_edge = k;
                break;
            end
        end

        if (stop_j < 64) begin
            @(posedge clk); #1;
            check("abort_idle_busy", {31'd0, busy}, 32'd0);
            bad = 0;
            for (int i = stop_j; i < 64; i++)
                if (out_mem[i] !== 8'hA5)
                    bad++;
            check("abort_untouched", bad, 0);
        end else begin
            check("done_edge", done_edge, 67);
            check("done_taps", {26'd0, taps}, {26'd0, model_taps(tap_b)});
        end
        check("queue_drained", exp_q.size(), 0);

        if (hold_chk) begin
            bad = 0;
            repeat (100) begin
                @(posedge clk); #1;
                if (done !== 1'b1 || bus.write_en !== 1'b0 || busy !== 1'b0)
                    bad++;
            end
            check("done_hold", bad, 0);
        end
    endtask

    initial begin
        int p_r;
        int t_r;
        int s_r;
        init    = 1'b1;
        clr_out = 1'b1;
        for (int i = 0; i < 64; i++)
            in_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Basic encode, followed by the done-hold window.
        fill_msg();
        in_mem[0] = 8'h41;
        run_enc(8'd7, 8'd0, 8'h01, 64, 1'b1);

        // Preamble clamps, out-of-range tap select, and zero seed.
        run_enc(8'd3,  8'd0, 8'h00, 64, 1'b0);
        run_enc(8'd20, 8'd7, 8'h05, 64, 1'b0);
        run_enc(8'd12, 8'd6, 8'hC0, 64, 1'b0);

        // All tap selects with seed 2A.
        fill_msg();
        for (int s = 0; s < 8; s++)
            run_enc(8'd9, 8'(s), 8'h2A, 64, 1'b0);

        // Reset during ENC at j = 30, then an identical rerun.
        fill_msg();
        run_enc(8'd8, 8'd3, 8'h17, 30, 1'b0);
        run_enc(8'd8, 8'd3, 8'h17, 64, 1'b0);

        // Randomized configurations and messages.
        for (int r = 0; r < 6; r++) begin
            fill_msg();
            p_r = $urandom_range(0, 30);
            t_r = $urandom_range(0, 255);
            s_r = $urandom_range(1, 255);
            run_enc(8'(p_r), 8'(t_r), 8'(s_r), 64, 1'b0);
        end

        init = 1'b1;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
